hld_multi: RTL and testbench

//  Parametrised harmonic-lock detector for the FMDLL lock loop. Observes the phase-detector

---
 rtl/hld_pkg.sv | 25 ++
 rtl/hld_multi_if.sv | 28 ++
 rtl/hld_window_chan.sv | 75 +++++++
 rtl/hld_multi.sv | 146 ++++++++++++++
 tb/tb_hld_multi.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/hld_pkg.sv
// Shared types and helpers for the harmonic-lock detector.
package hld_pkg;

  localparam int STATE_W = 2;
  localparam int SAT_W   = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRE  = 2'd2,
    HOLD  = 2'd3
  } hld_state_e;

  // Increment that sticks at the all-ones value of a w-bit field (w <= SAT_W).
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v, input int unsigned w);
    logic [SAT_W-1:0] max_v;
    max_v = SAT_W'((32'd1 << w) - 32'd1);
    if (v >= max_v) begin
      return max_v;
    end else begin
      return v + SAT_W'(1'b1);
    end
  endfunction

endpackage

// File: rtl/hld_multi_if.sv
// Control/status bundle between the lock loop and the harmonic-lock detector.
interface hld_multi_if #(
  parameter int NCH      = 2,
  parameter int CNT_W    = 8,
  parameter int THRESH_W = 4
) ();
  logic                    en;
  logic                    div_m;
  logic                    sel;
  logic [NCH*CNT_W-1:0]    win_start;
  logic [NCH*CNT_W-1:0]    win_end;
  logic [THRESH_W-1:0]     thresh;
  logic                    mode;
  logic                    clr;
  logic                    reset_pd;
  logic [NCH-1:0]          hld_vec;
  logic                    busy;

  modport master (
    output en, div_m, sel, win_start, win_end, thresh, mode, clr,
    input  reset_pd, hld_vec, busy
  );

  modport slave (
    input  en, div_m, sel, win_start, win_end, thresh, mode, clr,
    output reset_pd, hld_vec, busy
  );
endinterface

// File: rtl/hld_window_chan.sv
// One observation channel: window compare, per-period hit flag,
// consecutive-hit counter and lock flag.
module hld_window_chan
  import hld_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int THRESH_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                eval,
  input  logic                div_m,
  input  logic                sel,
  input  logic                prd_valid,
  input  logic [CNT_W-1:0]    pcnt,
  input  logic [CNT_W-1:0]    win_start,
  input  logic [CNT_W-1:0]    win_end,
  input  logic [THRESH_W-1:0] thresh,
  output logic                hld
);

  logic                win_open_s;
  logic                hit_now_s;
  logic [THRESH_W-1:0] cnt_next_s;
  logic [THRESH_W-1:0] thr_s;
  logic                hit_r;
  logic [THRESH_W-1:0] cnt_r;
  logic                hld_r;

  // Window decode and next-count; the div_m cycle's own sample is folded into hit_now_s.
  always_comb begin
    win_open_s = prd_valid && (pcnt >= win_start) && (pcnt <= win_end);
    hit_now_s  = hit_r | (sel & win_open_s);
    if (hit_now_s) begin
      cnt_next_s = THRESH_W'(sat_inc(SAT_W'(cnt_r), THRESH_W));
    end else begin
      cnt_next_s = {THRESH_W{1'b0}};
    end
    if (thresh == {THRESH_W{1'b0}}) begin
      thr_s = THRESH_W'(1'b1);
    end else begin
      thr_s = thresh;
    end
  end

  // Hit, counter and lock-flag state; frozen whenever the FSM is not ARMED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_r <= 1'b0;
      cnt_r <= {THRESH_W{1'b0}};
      hld_r <= 1'b0;
    end else if (clear) begin
      hit_r <= 1'b0;
      cnt_r <= {THRESH_W{1'b0}};
      hld_r <= 1'b0;
    end else if (eval && div_m) begin
      hit_r <= 1'b0;
      if (prd_valid) begin
        cnt_r <= cnt_next_s;
        hld_r <= hld_r | (cnt_next_s >= thr_s);
      end else begin
        cnt_r <= cnt_r;
        hld_r <= hld_r;
      end
    end else if (eval) begin
      hit_r <= hit_now_s;
    end else begin
      hit_r <= hit_r;
    end
  end

  assign hld = hld_r;

endmodule

// File: rtl/hld_multi.sv
// Harmonic-lock detector top: period counter, channel array and the
// IDLE/ARMED/FIRE/HOLD sequencer that drives the phase-detector reset pulse.
module hld_multi
  import hld_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int CNT_W     = 8,
  parameter int THRESH_W  = 4,
  parameter int PULSE_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  hld_multi_if.slave bus
);

  localparam int PW = $clog2(PULSE_LEN + 1);

  hld_state_e     state_r;
  logic [CNT_W-1:0] pcnt_r;
  logic           prd_valid_r;
  logic [PW-1:0]  pulse_r;
  logic           reset_pd_r;
  logic           busy_r;
  logic [NCH-1:0] hld_vec_s;
  logic           rearm_s;
  logic           clear_s;
  logic           eval_s;
  logic           any_hld_s;

  // Auto-rearm fires on the last pulse cycle and wipes the channels like a clear.
  always_comb begin
    rearm_s   = (state_r == FIRE) && (pulse_r == PW'(1'b1)) && bus.mode;
    clear_s   = !bus.en || bus.clr || rearm_s;
    eval_s    = (state_r == ARMED);
    any_hld_s = |hld_vec_s;
  end

  // In-period phase counter; prd_valid marks that a period has been opened.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_r      <= {CNT_W{1'b0}};
      prd_valid_r <= 1'b0;
    end else if (!bus.en || bus.clr) begin
      pcnt_r      <= {CNT_W{1'b0}};
      prd_valid_r <= 1'b0;
    end else begin
      if (bus.div_m) begin
        pcnt_r <= {CNT_W{1'b0}};
      end else begin
        pcnt_r <= CNT_W'(sat_inc(SAT_W'(pcnt_r), CNT_W));
      end
      if (rearm_s) begin
        prd_valid_r <= 1'b0;
      end else if (bus.div_m) begin
        prd_valid_r <= 1'b1;
      end else begin
        prd_valid_r <= prd_valid_r;
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    hld_window_chan #(
      .CNT_W    (CNT_W),
      .THRESH_W (THRESH_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear_s),
      .eval      (eval_s),
      .div_m     (bus.div_m),
      .sel       (bus.sel),
      .prd_valid (prd_valid_r),
      .pcnt      (pcnt_r),
      .win_start (bus.win_start[k*CNT_W +: CNT_W]),
      .win_end   (bus.win_end[k*CNT_W +: CNT_W]),
      .thresh    (bus.thresh),
      .hld       (hld_vec_s[k])
    );
  end

  // Sequencer with registered pulse/busy outputs; en and clr override every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      pulse_r    <= {PW{1'b0}};
      reset_pd_r <= 1'b0;
      busy_r     <= 1'b0;
    end else if (!bus.en) begin
      state_r    <= IDLE;
      pulse_r    <= {PW{1'b0}};
      reset_pd_r <= 1'b0;
      busy_r     <= 1'b0;
    end else if (bus.clr) begin
      state_r    <= ARMED;
      pulse_r    <= {PW{1'b0}};
      reset_pd_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= ARMED;
        end
        ARMED: begin
          if (any_hld_s) begin
            state_r    <= FIRE;
            pulse_r    <= PW'(PULSE_LEN);
            reset_pd_r <= 1'b1;
            busy_r     <= 1'b1;
          end else begin
            state_r <= ARMED;
          end
        end
        FIRE: begin
          if (pulse_r == PW'(1'b1)) begin
            pulse_r    <= {PW{1'b0}};
            reset_pd_r <= 1'b0;
            if (bus.mode) begin
              state_r <= ARMED;
              busy_r  <= 1'b0;
            end else begin
              state_r <= HOLD;
              busy_r  <= 1'b1;
            end
          end else begin
            pulse_r <= pulse_r - PW'(1'b1);
          end
        end
        HOLD: begin
          state_r <= HOLD;
        end
        default: begin
          state_r    <= IDLE;
          pulse_r    <= {PW{1'b0}};
          reset_pd_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.reset_pd = reset_pd_r;
  assign bus.busy     = busy_r;
  assign bus.hld_vec  = hld_vec_s;

endmodule

// File: tb/tb_hld_multi.sv
// Directed bench for hld_multi: 32-cycle reference periods, hand-computed
// lock/pulse expectations, outputs sampled on the falling edge.
module tb_hld_multi;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   rp_cnt = 0;

  always #5 clk = ~clk;

  hld_multi_if #(.NCH(2), .CNT_W(8), .THRESH_W(4)) bus ();

  hld_multi #(.NCH(2), .CNT_W(8), .THRESH_W(4), .PULSE_LEN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic rp, input logic [1:0] hv, input logic bz);
    check({tag, "_reset_pd"}, 32'(bus.reset_pd), 32'(rp));
    check({tag, "_hld_vec"},  32'(bus.hld_vec),  32'(hv));
    check({tag, "_busy"},     32'(bus.busy),     32'(bz));
  endtask

  // One clock: inputs applied at the falling edge, result observed at the next one.
  task automatic cyc(input logic d, input logic s);
    bus.div_m = d;
    bus.sel   = s;
    @(negedge clk);
    if (bus.reset_pd) rp_cnt++;
  endtask

  // 31 cycles with pcnt = 0..30, then the div_m cycle at pcnt = 31; sel_pc = -2 means sel always high.
  task automatic run_period(input int sel_pc);
    for (int j = 0; j < 32; j++) begin
      cyc(j == 31, (sel_pc == -2) || (sel_pc == j));
    end
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    cyc(1'b0, 1'b0);
    bus.clr = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.div_m     = 1'b0;
    bus.sel       = 1'b0;
    bus.clr       = 1'b0;
    bus.mode      = 1'b0;
    bus.thresh    = 4'd3;
    bus.win_start = {8'd20, 8'd10};
    bus.win_end   = {8'd5,  8'd12};
    repeat (3) @(negedge clk);
    chk_out("reset", 1'b0, 2'b00, 1'b0);

    // Sticky lock after three consecutive hits at pcnt=11
    rst    = 1'b0;
    bus.en = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    run_period(11);
    run_period(11);
    check("t1_two_hits_hld", 32'(bus.hld_vec), 32'd0);
    run_period(11);
    chk_out("t1_lock", 1'b0, 2'b01, 1'b0);
    cyc(1'b0, 1'b0);
    chk_out("t1_fire", 1'b1, 2'b01, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0);
      check("t1_pulse_high", 32'(bus.reset_pd), 32'd1);
    end
    cyc(1'b0, 1'b0);
    chk_out("t1_hold", 1'b0, 2'b01, 1'b1);
    run_period(11);
    chk_out("t1_hold_frozen", 1'b0, 2'b01, 1'b1);
    do_clr();
    chk_out("t1_clr", 1'b0, 2'b00, 1'b0);

    // A miss resets the consecutive count; clr aborts the pulse on its 2nd cycle
    cyc(1'b1, 1'b0);
    run_period(11);
    run_period(11);
    run_period(99);
    run_period(11);
    check("t2_miss_hit1_hld", 32'(bus.hld_vec), 32'd0);
    run_period(11);
    check("t2_miss_hit2_hld", 32'(bus.hld_vec), 32'd0);
    run_period(11);
    check("t2_miss_hit3_hld", 32'(bus.hld_vec), 32'd1);
    cyc(1'b0, 1'b0);
    check("t2_pulse1", 32'(bus.reset_pd), 32'd1);
    cyc(1'b0, 1'b0);
    check("t2_pulse2", 32'(bus.reset_pd), 32'd1);
    do_clr();
    chk_out("t2_clr_abort", 1'b0, 2'b00, 1'b0);

    // Full pulse length, then en=0 from HOLD
    cyc(1'b1, 1'b0);
    repeat (3) run_period(11);
    rp_cnt = 0;
    repeat (6) cyc(1'b0, 1'b0);
    check("t3_pulse_len", 32'(rp_cnt), 32'd4);
    chk_out("t3_hold", 1'b0, 2'b01, 1'b1);
    bus.en = 1'b0;
    cyc(1'b0, 1'b0);
    chk_out("t3_en_off", 1'b0, 2'b00, 1'b0);
    run_period(11);
    chk_out("t3_idle", 1'b0, 2'b00, 1'b0);

    // Auto-rearm with sel continuously high; window 1 (start>end) never hits
    bus.en   = 1'b1;
    bus.mode = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    repeat (3) run_period(-2);
    check("t4_lock", 32'(bus.hld_vec), 32'd1);
    rp_cnt = 0;
    run_period(-2);
    check("t4_pulse1_len", 32'(rp_cnt), 32'd4);
    chk_out("t4_rearm", 1'b0, 2'b00, 1'b0);
    run_period(-2);
    run_period(-2);
    check("t4_two_evals_hld", 32'(bus.hld_vec), 32'd0);
    run_period(-2);
    check("t4_relock", 32'(bus.hld_vec), 32'd1);
    rp_cnt = 0;
    run_period(-2);
    check("t4_pulse2_len", 32'(rp_cnt), 32'd4);

    // div_m coincident with sel at pcnt=31, window 1 = [31,31], thresh=0 acts as 1
    bus.mode      = 1'b0;
    bus.thresh    = 4'd0;
    bus.win_start = {8'd31, 8'd10};
    bus.win_end   = {8'd31, 8'd12};
    do_clr();
    cyc(1'b1, 1'b0);
    run_period(31);
    check("t5_coincident_hld", 32'(bus.hld_vec), 32'd2);
    cyc(1'b0, 1'b0);
    check("t5_fire", 32'(bus.reset_pd), 32'd1);

    // Asynchronous reset in the middle of the pulse
    #2 rst = 1'b1;
    #1 chk_out("rst_async", 1'b0, 2'b00, 1'b0);
    bus.en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    chk_out("rst_idle", 1'b0, 2'b00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
